// File: rtl/ws2812b_encoder.sv
`timescale 1ns/1ps
// WS2812B single-wire NRZ encoder: 24-bit GRB pixels in, LED data waveform out.
// Latency: DOUT rises on the cycle after a pixel is accepted; bits are BIT_CYCLES long, MSB (G7) first.
// Backpressure: PIX_READY only in IDLE or on the last cycle of a non-last pixel; a frame ends with a LATCH_CYCLES low gap.
//
// Ports:
//   CLK        system clock
//   RST_N      synchronous active-low reset (enters the latch gap)
//   PIX_DATA   pixel, [23:16]=G, [15:8]=R, [7:0]=B
//   PIX_LAST   pixel closes the frame (qualified by the handshake)
//   PIX_VALID  upstream presents a pixel
//   PIX_READY  encoder takes the pixel on this edge (combinational)
//   DOUT       registered serial data to the LED chain
//   BUSY       encoder is not idle
module ws2812b_encoder #(
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 5,
  parameter int T1H_CYCLES   = 10,
  parameter int LATCH_CYCLES = 960
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_LAST,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        DOUT,
  output logic        BUSY
);

  localparam int CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] BIT_END   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_END = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] T0H       = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H       = CW'(T1H_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic          last_q, last_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          dout_q, dout_d;

  logic          pix_ready;
  logic [CW-1:0] cyc_inc;
  logic [CW-1:0] high_len;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_LATCH;
      shift_q   <= '0;
      last_q    <= 1'b0;
      bit_idx_q <= '0;
      cyc_q     <= '0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      bit_idx_q <= bit_idx_d;
      cyc_q     <= cyc_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    bit_idx_d = bit_idx_q;
    cyc_d     = cyc_q;
    dout_d    = dout_q;
    pix_ready = 1'b0;
    cyc_inc   = cyc_q + CW'(1);
    high_len  = shift_q[23] ? T1H : T0H;

    case (state_q)
      S_IDLE: begin
        pix_ready = 1'b1;
        dout_d    = 1'b0;
        if (PIX_VALID) begin
          shift_d   = PIX_DATA;
          last_d    = PIX_LAST;
          bit_idx_d = '0;
          cyc_d     = '0;
          dout_d    = 1'b1;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (cyc_q != BIT_END) begin
          cyc_d  = cyc_inc;
          // DOUT is registered, so decide the level of the cycle being entered.
          dout_d = (cyc_inc < high_len);
        end else begin
          cyc_d = '0;
          if (bit_idx_q != 5'd23) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q + 5'd1;
            dout_d    = 1'b1;
          end else begin
            // Chaining a follow-on pixel here keeps the bit period seamless.
            pix_ready = !last_q;
            if (!last_q && PIX_VALID) begin
              shift_d   = PIX_DATA;
              last_d    = PIX_LAST;
              bit_idx_d = '0;
              dout_d    = 1'b1;
            end else begin
              dout_d  = 1'b0;
              state_d = S_LATCH;
            end
          end
        end
      end

      S_LATCH: begin
        dout_d = 1'b0;
        if (cyc_q == LATCH_END) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_inc;
        end
      end

      default: begin
        dout_d  = 1'b0;
        cyc_d   = '0;
        state_d = S_LATCH;
      end
    endcase
  end

  assign PIX_READY = pix_ready;
  assign DOUT      = dout_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ws2812b_encoder.sv
`timescale 1ns/1ps
module tb_ws2812b_encoder;

  localparam int BITC  = 15;
  localparam int T0H   = 5;
  localparam int T1H   = 10;
  localparam int LATCH = 960;

  logic        CLK;
  logic        RST_N;
  logic [23:0] PIX_DATA;
  logic        PIX_LAST;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic        DOUT;
  logic        BUSY;

  ws2812b_encoder #(
    .BIT_CYCLES  (BITC),
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .LATCH_CYCLES(LATCH)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .PIX_DATA (PIX_DATA),
    .PIX_LAST (PIX_LAST),
    .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY),
    .DOUT     (DOUT),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp_v);
    end
  endtask

  // ---------------- reference model: queue of future DOUT samples ----------
  localparam logic [1:0] K_DATA = 2'd0, K_END_OPEN = 2'd1, K_END_LAST = 2'd2, K_LATCH = 2'd3;
  typedef struct packed {
    logic       d;
    logic [1:0] k;
  } ent_t;

  ent_t mq[$];
  bit   m_on = 1'b0;

  task automatic model_add_latch();
    ent_t e;
    e.d = 1'b0;
    e.k = K_LATCH;
    for (int i = 0; i < LATCH; i++) mq.push_back(e);
  endtask

  task automatic model_add_pixel(input logic [23:0] px, input logic last);
    ent_t e;
    int   h;
    for (int b = 23; b >= 0; b--) begin
      h = px[b] ? T1H : T0H;
      for (int c = 0; c < BITC; c++) begin
        e.d = (c < h);
        e.k = (b == 0 && c == BITC - 1) ? (last ? K_END_LAST : K_END_OPEN) : K_DATA;
        mq.push_back(e);
      end
    end
  endtask

  always @(negedge CLK) begin : model
    logic exp_d, exp_b, exp_r, take, popped;
    ent_t pe;
    exp_d  = (mq.size() != 0) ? mq[0].d : 1'b0;
    exp_b  = (mq.size() != 0);
    exp_r  = (mq.size() == 0) || (mq[0].k == K_END_OPEN);
    popped = 1'b0;
    pe     = '0;
    if (m_on) begin
      check("model_dout",  int'(DOUT),      int'(exp_d));
      check("model_busy",  int'(BUSY),      int'(exp_b));
      check("model_ready", int'(PIX_READY), int'(exp_r));
    end
    if (!RST_N) begin
      mq.delete();
      model_add_latch();
      m_on = 1'b1;
    end else if (m_on) begin
      take = PIX_VALID && exp_r;
      if (mq.size() != 0) begin
        pe     = mq.pop_front();
        popped = 1'b1;
      end
      if (take) model_add_pixel(PIX_DATA, PIX_LAST);
      else if (popped && (pe.k == K_END_OPEN || pe.k == K_END_LAST)) model_add_latch();
    end
  end

  // ---------------- stimulus driver and observation logs -------------------
  typedef struct packed {
    logic [23:0] data;
    logic        last;
  } pix_t;

  pix_t stim_q[$];
  logic dout_log[$];
  logic ready_log[$];
  logic busy_log[$];
  bit   last_xfer = 1'b0;
  int   xfer_cnt  = 0;

  task automatic drive();
    if (stim_q.size() != 0) begin
      PIX_VALID = 1'b1;
      PIX_DATA  = stim_q[0].data;
      PIX_LAST  = stim_q[0].last;
    end else begin
      PIX_VALID = 1'b0;
      PIX_DATA  = '0;
      PIX_LAST  = 1'b0;
    end
  endtask

  task automatic push(input logic [23:0] d, input logic l);
    pix_t p;
    p.data = d;
    p.last = l;
    stim_q.push_back(p);
    drive();
  endtask

  task automatic clear_logs();
    dout_log.delete();
    ready_log.delete();
    busy_log.delete();
  endtask

  // One clock cycle: sample away from the edge, then update inputs after it.
  task automatic step();
    @(negedge CLK);
    last_xfer = PIX_VALID && PIX_READY && RST_N;
    dout_log.push_back(DOUT);
    ready_log.push_back(PIX_READY);
    busy_log.push_back(BUSY);
    @(posedge CLK);
    #1;
    if (last_xfer) begin
      xfer_cnt++;
      void'(stim_q.pop_front());
    end
    drive();
  endtask

  task automatic wait_xfer(input string nm, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_xfer && n <= budget);
    if (!last_xfer) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_until_idle(input string nm, input int budget, output int busy_n);
    busy_n = 0;
    forever begin
      step();
      if (!busy_log[busy_log.size() - 1]) break;
      busy_n++;
      if (busy_n > budget) begin
        check({nm, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  function automatic int hi_prefix(input int base);
    int n = 0;
    while (n < BITC && dout_log[base + n] == 1'b1) n++;
    return n;
  endfunction

  function automatic int ones_in(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (dout_log[i] == 1'b1) n++;
    return n;
  endfunction

  function automatic int zeros_ready();
    int n = 0;
    for (int i = 0; i < ready_log.size(); i++) if (ready_log[i] == 1'b0) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, x0, rises, bad, prev;
    logic [23:0] w;

    RST_N = 1'b0;
    drive();

    // --- reset and release with a pixel already pending
    push(24'h000001, 1'b1);
    clear_logs();
    repeat (3) step();
    check("rst_dout",  int'(dout_log[2]),  0);
    check("rst_ready", int'(ready_log[2]), 0);
    check("rst_busy",  int'(busy_log[2]),  1);
    RST_N = 1'b1;
    clear_logs();
    wait_xfer("rel", 2000);
    check("rel_ready_low_cycles", zeros_ready(), 960);
    check("rel_dout_ones", ones_in(0, dout_log.size()), 0);
    run_until_idle("rel_frame", 3000, n);
    check("rel_frame_len", n, 1320);

    // --- single pixel 0x800001
    push(24'h800001, 1'b1);
    wait_xfer("single", 50);
    clear_logs();
    run_until_idle("single_frame", 3000, n);
    check("single_frame_len", n, 1320);
    check("single_bit0_high",  hi_prefix(0),       10);
    check("single_bit1_high",  hi_prefix(15),      5);
    check("single_bit22_high", hi_prefix(22 * 15), 5);
    check("single_bit23_high", hi_prefix(23 * 15), 10);
    check("single_total_high", ones_in(0, 360), 130);
    bad = 0;
    for (int k = 0; k < 24; k++) if (ones_in(15 * k, 15 * k + 15) != hi_prefix(15 * k)) bad++;
    check("single_nonprefix_bits", bad, 0);
    check("single_latch_ones", ones_in(360, 1320), 0);

    // --- two back-to-back pixels, VALID held
    push(24'hFFFFFF, 1'b0);
    push(24'h000000, 1'b1);
    wait_xfer("b2b", 50);
    x0 = xfer_cnt;
    clear_logs();
    run_until_idle("b2b_frame", 4000, n);
    check("b2b_frame_len", n, 1680);
    check("b2b_xfers", xfer_cnt - x0, 1);
    n = 0;
    for (int i = 0; i < 720; i++) if (ready_log[i] == 1'b1) n++;
    check("b2b_ready_pulses", n, 1);
    check("b2b_ready_at_359", int'(ready_log[359]), 1);
    rises = 0;
    bad   = 0;
    prev  = 0;
    for (int i = 0; i < 720; i++) begin
      if (dout_log[i] == 1'b1 && prev == 0) begin
        rises++;
        if (i % 15 != 0) bad++;
      end
      prev = int'(dout_log[i]);
    end
    check("b2b_rises", rises, 48);
    check("b2b_offgrid_rises", bad, 0);
    bad = 0;
    for (int k = 0; k < 48; k++) if (hi_prefix(15 * k) != ((k < 24) ? 10 : 5)) bad++;
    check("b2b_bad_high_times", bad, 0);

    // --- underrun: frame ends, a new pixel stalls through the gap
    push(24'hA5A5A5, 1'b0);
    wait_xfer("under", 50);
    clear_logs();
    repeat (460) step();
    check("under_ready_end_pixel", int'(ready_log[359]), 1);
    check("under_busy_in_latch", int'(busy_log[459]), 1);
    push(24'h123456, 1'b1);
    clear_logs();
    wait_xfer("under_stall", 2000);
    check("under_stall_cycles", zeros_ready(), 860);
    run_until_idle("under_frame", 3000, n);
    check("under_frame_len", n, 1320);

    // --- reset in the middle of bit 7 of a '1' pixel
    push(24'hFFFFFF, 1'b1);
    wait_xfer("midrst", 50);
    clear_logs();
    repeat (108) step();
    RST_N = 1'b0;
    step();
    step();
    check("midrst_dout_before", int'(dout_log[108]), 1);
    check("midrst_dout_after",  int'(dout_log[109]), 0);
    check("midrst_busy_after",  int'(busy_log[109]), 1);
    RST_N = 1'b1;
    push(24'h0F0F0F, 1'b1);
    clear_logs();
    wait_xfer("midrst_rel", 2000);
    check("midrst_ready_low_cycles", zeros_ready(), 960);
    run_until_idle("midrst_frame", 3000, n);
    check("midrst_frame_len", n, 1320);

    // --- pixel held through the latch gap is taken exactly once, intact
    push(24'h000000, 1'b1);
    wait_xfer("stall", 50);
    clear_logs();
    repeat (400) step();
    x0 = xfer_cnt;
    push(24'h5AC3E7, 1'b1);
    clear_logs();
    wait_xfer("stall_wait", 2000);
    check("stall_ready_low_cycles", zeros_ready(), 920);
    clear_logs();
    run_until_idle("stall_frame", 3000, n);
    check("stall_frame_len", n, 1320);
    w = '0;
    for (int k = 0; k < 24; k++) w = {w[22:0], (hi_prefix(15 * k) == T1H)};
    check("stall_decoded", int'(w), int'(24'h5AC3E7));
    check("stall_xfers", xfer_cnt - x0, 1);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812b_encoder.md
Name: ws2812b_encoder

Overview:
Serial line encoder for a WS2812B LED chain. It accepts 24-bit GRB pixels over a valid/ready stream from the pattern/frame logic and emits the single-wire NRZ waveform on DOUT, which drives the LED data pin (PIN_24 at top level). It inserts the latch/reset low period at the end of each frame and after system reset. All timing is expressed in CLK cycles; the defaults assume the 12 MHz board clock (83.3 ns per cycle).

Parameters:
BIT_CYCLES, 15, total cycles per data bit (1.25 us)
T0H_CYCLES, 5, high cycles for a '0' bit (~0.42 us)
T1H_CYCLES, 10, high cycles for a '1' bit (~0.83 us)
LATCH_CYCLES, 960, low cycles for the latch/reset gap (80 us); constraint: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES

Ports:
CLK  input  1  system clock
RST_N  input  1  synchronous reset, active-low
PIX_DATA  input  24  pixel, GRB order, [23:16]=G, [15:8]=R, [7:0]=B
PIX_LAST  input  1  pixel is the last of the frame; qualified by handshake
PIX_VALID  input  1  upstream presents a pixel
PIX_READY  output  1  encoder accepts the pixel this cycle
DOUT  output  1  WS2812B serial data
BUSY  output  1  high whenever state is not IDLE

Behaviour:
- The design has one clock, CLK. Reset is synchronous and active-low on RST_N: it is sampled only on the CLK rising edge.
- States: IDLE, SEND, LATCH. Registers: shift reg (24), last_q, bit_idx (0..23), cyc counter (width ceil(log2(max(BIT_CYCLES,LATCH_CYCLES)))), DOUT (registered).
- Reset (RST_N=0 at an edge): state=LATCH, cyc=0, DOUT=0, last_q=0. Outputs during and directly after reset: DOUT=0, PIX_READY=0, BUSY=1. Reset applies mid-pixel or mid-latch with no partial bit completion.
- Handshake: a transfer occurs on an edge where PIX_VALID=1 and PIX_READY=1. PIX_DATA and PIX_LAST must be held stable while VALID=1 and READY=0.
- PIX_READY is combinational:
  - 1 in IDLE;
  - 1 in SEND only on the final cycle of bit 23 (bit_idx=23, cyc=BIT_CYCLES-1) and only when last_q=0;
  - 0 otherwise, including all of LATCH.
- IDLE: DOUT=0. On a transfer, load shift reg and last_q, set bit_idx=0 and cyc=0, set DOUT=1 at that same edge, then go to SEND. DOUT is high from the cycle after acceptance (latency 1).
- SEND: the current bit is the shift-reg MSB; bits go out MSB first (G7 first, B0 last).
  - DOUT=1 for cycles 0..TxH-1 of the bit, 0 for cycles TxH..BIT_CYCLES-1, where TxH = T1H_CYCLES for a '1' and T0H_CYCLES for a '0'.
  - At cyc=BIT_CYCLES-1, cyc wraps to 0.
  - If bit_idx<23: shift left, bit_idx+1, DOUT=1 at the same edge. There is no gap between bits.
- End of pixel (bit 23, final cycle):
  - transfer occurs: load the new pixel, bit_idx=0, DOUT=1, stay in SEND. This gives a seamless 15-cycle period across pixels.
  - no transfer (underrun, or last_q=1): DOUT=0, cyc=0, go to LATCH.
- LATCH: DOUT=0 for exactly LATCH_CYCLES cycles. At cyc=LATCH_CYCLES-1 go to IDLE, so READY=1 on the following cycle.
- An underrun therefore ends the frame. The LEDs latch whatever was sent, and the next pixel starts a new frame from LED 0.
- BUSY = (state != IDLE).
- PIX_VALID asserted during LATCH is ignored (READY=0) and held until IDLE.
- Frame waveform length = 24*BIT_CYCLES*N + LATCH_CYCLES cycles for N back-to-back pixels.

Test Plan:
- Reset release: RST_N low 3 cycles then high, PIX_VALID=1 with 0x000001, LAST=1 → DOUT=0 and READY=0 for 960 cycles after reset release, then READY=1 and the pixel is accepted on the next edge.
- Single pixel 0x800001, LAST=1 → bit0: DOUT high 10 cycles and low 5; bits 1..22: high 5, low 10; bit 23: high 10, low 5; then 960 low cycles; BUSY deasserts; total 360+960 cycles.
- Two back-to-back pixels 0xFFFFFF then 0x000000 (LAST on the 2nd), VALID held → READY pulses exactly one cycle at end of pixel 1. DOUT shows 48 rising edges at a constant 15-cycle spacing; the first 24 high-times are 10 cycles and the last 24 are 5.
- Underrun: pixel 1 with LAST=0, VALID deasserted at the end of pixel 1 → LATCH entered; a pixel presented 100 cycles later stays stalled (READY=0) until the 960-cycle gap completes.
- Mid-pixel reset: assert RST_N=0 at bit 7, cycle 3 of a '1' bit → DOUT=0 from the next edge, BUSY=1; after release, a full 960-cycle low completes before READY=1.
- Stall stability: VALID=1 with changing-free data held during LATCH; check exactly one transfer occurs and the emitted bit pattern matches the held PIX_DATA.
